booth_mult_arbiter: RTL and testbench
=====================================

// Module: booth_mult_arbiter
// PURPOSE
//  Shares one sequential Booth multiplier core (controller + datapath) between NREQ requesters.
//  Per operation: round-robin grant, operand capture, core clear, start pulse, wait for done, then return the tagged product.
//  Sits between client blocks and the core. The core's done state is terminal, so the core is cleared before every launch.
// PARAMETERS
//  WIDTH    16  operand width (signed two's complement); product is 2*WIDTH bits
//  NREQ     4   number of requesters, 2..8
//  IDW      2   requester-id width, $clog2(NREQ)
//  TIMEOUT  64  WAIT-state cycle limit; used only with MUL_TIMEOUT_EN
// PORTS
//  clk         in   1           rising-edge clock, single clock domain
//  rst_n       in   1           asynchronous active-low reset
//  req_valid   in   NREQ        per-requester request valid
//  req_ready   out  NREQ        one-hot grant pulse; accepts the request
//  req_a       in   NREQ*WIDTH  multiplicand per requester, packed (slot i at [i*WIDTH+:WIDTH])
//  req_b       in   NREQ*WIDTH  multiplier per requester, packed
//  mul_clr     out  1           synchronous clear to the core (controller to S0, registers to 0)
//  mul_start   out  1           start strobe to the core
//  mul_m       out  WIDTH       M operand to the core, held stable from CLR to RESP
//  mul_q       out  WIDTH       Q operand to the core, held stable from CLR to RESP
//  mul_done    in   1           core done level
//  mul_result  in   2*WIDTH     core product {A,Q}, valid while mul_done=1
//  rsp_valid   out  1           response valid
//  rsp_ready   in   1           response accept
//  rsp_id      out  IDW         requester index of the response
//  rsp_data    out  2*WIDTH     signed product
//  rsp_err     out  1           operation aborted by timeout (always 0 without MUL_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NREQ-1, all outputs 0. Reset is asynchronous assertion and applies mid-operation.
//    On release, the next operation clears the core first, so a stale core state is harmless.
//  FSM: IDLE -> CLR -> LAUNCH -> WAIT -> RESP -> IDLE.
//   IDLE: if |req_valid, grant the first set index at or after rr_ptr+1 (mod NREQ).
//     Pulse req_ready[g]=1 for exactly that cycle.
//     Capture a/b into mul_m/mul_q and g into rsp_id. Set rr_ptr<=g. Go to CLR.
//   CLR: mul_clr=1 for 2 cycles, then go to LAUNCH.
//   LAUNCH: mul_start=1 held until mul_done=0 is seen with start already sampled. Minimum 2 cycles.
//     The core samples start only in its idle state. Then go to WAIT.
//   WAIT: mul_start=0. On mul_done=1, register rsp_data<=mul_result, rsp_err=0, go to RESP.
//   RESP: rsp_valid=1. rsp_id/rsp_data/rsp_err stay stable until rsp_ready=1.
//     The handshake completes that cycle; next cycle is IDLE with rsp_valid=0.
//     No new grant while in CLR..RESP; at most one operation in flight.
//  Requester rules: req_valid/req_a/req_b stay stable until req_ready. Dropping valid before grant withdraws the request.
//  Simultaneous valids: round-robin fairness. A requester re-asserting right after service waits behind all others.
//  Back-to-back: a new grant is possible in the cycle after rsp_ready handshake. No bubble beyond the IDLE cycle.
//  Latency (grant to rsp_valid): 2 CLR + 2 LAUNCH + core cycles (about 3*WIDTH) + 1.
//  Arithmetic: full signed product, no truncation. -2^(W-1) * -2^(W-1) = +2^(2W-2) fits in 2*WIDTH bits.
//  mul_done high on the first WAIT cycle (stale) cannot occur, because CLR forces the core idle.
// CONFIGURATION
//  MUL_TIMEOUT_EN defined: a cycle counter runs in WAIT. After TIMEOUT cycles without mul_done, go to RESP.
//    Response is rsp_err=1, rsp_data=0. The next operation clears the core as usual.
//  MUL_TIMEOUT_EN undefined: no counter, WAIT is unbounded, rsp_err tied 0.
// TESTING
//  1. Single request, req 1: a=3, b=-5 -> one req_ready[1] pulse; rsp_id=1, rsp_data=32'hFFFF_FFF1, rsp_err=0.
//  2. All 4 valid continuously after reset -> grants in order 0,1,2,3,0. Each product is correct and matches its id.
//  3. rsp_ready low for 10 cycles in RESP -> rsp_* stable, no req_ready pulse. Release -> grant next cycle.
//  4. a=b=-32768 -> rsp_data=32'h4000_0000. a=0, b=-1 -> rsp_data=0. a=32767, b=-32768 -> 32'hC000_8000.
//  5. rst_n low during WAIT -> outputs 0 asynchronously. After release, a new request (7*6) returns 42.
//  6. MUL_TIMEOUT_EN, TIMEOUT=64, mul_done tied 0 -> rsp_valid with rsp_err=1, rsp_data=0 after 64 WAIT cycles.
//     Then a normal op (2*2) completes with 4.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that shares one sequential Booth multiplier core between NREQ requesters.
// Optional WAIT-state watchdog enabled by defining MUL_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    mul_clr,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_m,
    output logic [WIDTH-1:0]        mul_q,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err
);

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_cfg
        $error("booth_mult_arbiter: unsupported parameter combination");
    end

    typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT, RESP} state_t;

    localparam int SW = IDW + 2;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic               phase;
    logic               grant_any;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     grant_off;
    logic [IDW:0]       shamt;
    logic [2*NREQ-1:0]  dbl;
    logic [NREQ-1:0]    rotated;
    logic [SW-1:0]      idx_sum;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Rotate the valids so bit 0 is the slot just after the last grant, then pick the lowest set bit.
    always_comb begin
        shamt     = {1'b0, rr_ptr} + (IDW+1)'(1);
        dbl       = {req_valid, req_valid} >> shamt;
        rotated   = dbl[NREQ-1:0];
        grant_any = 1'b0;
        grant_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                grant_any = 1'b1;
                grant_off = IDW'(i);
            end
        end
        idx_sum = {2'b00, rr_ptr} + SW'(1) + {2'b00, grant_off};
        if (idx_sum >= SW'(NREQ)) begin
            idx_sum = idx_sum - SW'(NREQ);
        end
        grant_idx = idx_sum[IDW-1:0];
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The grant must be combinational so a withdrawn request is never accepted.
    assign req_ready = (state == IDLE && grant_any) ? (NREQ'(1) << grant_idx) : '0;

`ifdef MUL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NREQ - 1);
            phase     <= 1'b0;
            mul_clr   <= 1'b0;
            mul_start <= 1'b0;
            mul_m     <= '0;
            mul_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef MUL_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_m   <= sel_a;
                        mul_q   <= sel_b;
                        rsp_id  <= grant_idx;
                        rr_ptr  <= grant_idx;
                        mul_clr <= 1'b1;
                        phase   <= 1'b0;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase     <= 1'b0;
                        mul_clr   <= 1'b0;
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                // First LAUNCH cycle lets the idle core sample start; leave once it reports busy.
                LAUNCH: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else if (!mul_done) begin
                        phase     <= 1'b0;
                        mul_start <= 1'b0;
`ifdef MUL_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_data  <= mul_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef MUL_TIMEOUT_EN
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + TW'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier core model.
// Define MUL_TIMEOUT_EN to also run the watchdog scenario.
module tb_booth_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        mul_clr;
    logic        mul_start;
    logic [15:0] mul_m;
    logic [15:0] mul_q;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    booth_mult_arbiter #(.WIDTH(16), .NREQ(4), .IDW(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_clr(mul_clr), .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Core model: clear to idle, sample start only when idle, done is terminal until the next clear.
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} core_t;
    core_t              cst = C_IDLE;
    int                 core_cnt = 0;
    logic               core_hang = 1'b0;
    logic signed [15:0] cm = '0;
    logic signed [15:0] cq = '0;

    always @(posedge clk) begin
        if (mul_clr) begin
            cst        <= C_IDLE;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            case (cst)
                C_IDLE: if (mul_start) begin
                    cst      <= C_BUSY;
                    core_cnt <= 9;
                    cm       <= mul_m;
                    cq       <= mul_q;
                end
                C_BUSY: if (!core_hang) begin
                    if (core_cnt == 0) begin
                        cst        <= C_DONE;
                        mul_done   <= 1'b1;
                        mul_result <= 32'(cm) * 32'(cq);
                    end else begin
                        core_cnt <= core_cnt - 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_valid[id]      = 1'b1;
    endtask

    task automatic await_grant(input int id, output logic ok, output logic [3:0] seen);
        ok   = 1'b0;
        seen = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (req_ready[id]) begin
                ok   = 1'b1;
                seen = req_ready;
                step();
                req_valid[id] = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    task automatic wait_resp(output logic ok, output int clr_c, output int start_c, output int wait_c);
        ok      = 1'b0;
        clr_c   = 0;
        start_c = 0;
        wait_c  = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
            end else begin
                if (mul_clr) clr_c++;
                if (mul_start) start_c++;
                if (!mul_clr && !mul_start) wait_c++;
                step();
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: valid=%b err=%b required 0 0", rsp_valid, rsp_err);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b required 0000", req_ready);
        end
        checks++;
        if (mul_clr !== 1'b0 || mul_start !== 1'b0) begin
            errors++; $display("FAIL reset_core_ctl: clr=%b start=%b required 0 0", mul_clr, mul_start);
        end
        checks++;
        if (mul_m !== 16'h0 || mul_q !== 16'h0) begin
            errors++; $display("FAIL reset_operands: m=%h q=%h required 0 0", mul_m, mul_q);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_data: id=%0d data=%h required 0 0", rsp_id, rsp_data);
        end
    endtask

    task automatic test_single;
        logic ok;
        logic [3:0] seen;
        int cc, sc, wc;
        rsp_ready = 1'b1;
        set_req(1, 16'd3, 16'hFFFB);
        await_grant(1, ok, seen);
        checks++;
        if (!ok || seen !== 4'b0010) begin
            errors++; $display("FAIL single_grant: got ok=%b ready=%b required 1 0010", ok, seen);
        end
        wait_resp(ok, cc, sc, wc);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout: no rsp_valid within bound");
        end
        checks++;
        if (rsp_id !== 2'd1 || rsp_data !== 32'hFFFF_FFF1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp: id=%0d data=%h err=%b required 1 fffffff1 0", rsp_id, rsp_data, rsp_err);
        end
        checks++;
        if (cc !== 2) begin
            errors++; $display("FAIL single_clr_len: got %0d cycles required 2", cc);
        end
        checks++;
        if (sc !== 2) begin
            errors++; $display("FAIL single_start_len: got %0d cycles required 2", sc);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_handshake: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_data [4];
        int grants [5];
        int rids [5];
        logic [31:0] rdata [5];
        int gcount, rcount, hs_cyc, cc, sc, wc;
        logic ok;
        exp_data[0] = 32'hFFFF_FD44;
        exp_data[1] = 32'hFFFE_F210;
        exp_data[2] = 32'h0000_FFFE;
        exp_data[3] = 32'h0000_0009;
        gcount = 0;
        rcount = 0;
        hs_cyc = 0;
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'd100,   16'hFFF9);
        set_req(1, 16'hFB2E,  16'd56);
        set_req(2, 16'd32767, 16'd2);
        set_req(3, 16'hFFFD,  16'hFFFD);
        for (int cyc = 0; cyc < 600 && gcount < 5; cyc++) begin
            #1;
            if (req_ready != 4'b0000) begin
                for (int k = 0; k < 4; k++) if (req_ready[k]) grants[gcount] = k;
                checks++;
                if (gcount != rcount) begin
                    errors++; $display("FAIL rr_in_flight: grant %0d issued with %0d responses required %0d", gcount, rcount, gcount);
                end
                if (gcount > 0) begin
                    checks++;
                    if (cyc != hs_cyc + 1) begin
                        errors++; $display("FAIL rr_back_to_back: grant at cycle %0d required %0d", cyc, hs_cyc + 1);
                    end
                end
                gcount++;
            end
            if (rsp_valid && rsp_ready && rcount < 5) begin
                rids[rcount]  = int'(rsp_id);
                rdata[rcount] = rsp_data;
                rcount++;
                hs_cyc = cyc;
            end
            step();
        end
        req_valid = '0;
        wait_resp(ok, cc, sc, wc);
        if (ok && rcount < 5) begin
            rids[rcount]  = int'(rsp_id);
            rdata[rcount] = rsp_data;
            rcount++;
        end
        step();
        checks++;
        if (gcount != 5 || rcount != 5) begin
            errors++; $display("FAIL rr_counts: grants=%0d responses=%0d required 5 5", gcount, rcount);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grants[k] != (k % 4)) begin
                    errors++; $display("FAIL rr_order: grant %0d went to %0d required %0d", k, grants[k], k % 4);
                end
                checks++;
                if (rids[k] != grants[k] || rdata[k] !== exp_data[k % 4]) begin
                    errors++; $display("FAIL rr_product: rsp %0d id=%0d data=%h required %0d %h", k, rids[k], rdata[k], k % 4, exp_data[k % 4]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic ok;
        logic [3:0] seen;
        int cc, sc, wc;
        rsp_ready = 1'b0;
        set_req(2, 16'd5, 16'd6);
        await_grant(2, ok, seen);
        checks++;
        if (!ok || seen !== 4'b0100) begin
            errors++; $display("FAIL bp_grant: got ok=%b ready=%b required 1 0100", ok, seen);
        end
        wait_resp(ok, cc, sc, wc);
        set_req(3, 16'hFFFE, 16'd7);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd30 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_hold: cycle %0d valid=%b id=%0d data=%h ready=%b required 1 2 0000001e 0000", i, rsp_valid, rsp_id, rsp_data, req_ready);
            end
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b required 0 1000", rsp_valid, req_ready);
        end
        step();
        req_valid[3] = 1'b0;
        wait_resp(ok, cc, sc, wc);
        checks++;
        if (!ok || rsp_id !== 2'd3 || rsp_data !== 32'hFFFF_FFF2) begin
            errors++; $display("FAIL bp_next: ok=%b id=%0d data=%h required 1 3 fffffff2", ok, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_corners;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [31:0] ve [3];
        logic ok;
        logic [3:0] seen;
        int cc, sc, wc;
        va[0] = 16'h8000; vb[0] = 16'h8000; ve[0] = 32'h4000_0000;
        va[1] = 16'h0000; vb[1] = 16'hFFFF; ve[1] = 32'h0000_0000;
        va[2] = 16'h7FFF; vb[2] = 16'h8000; ve[2] = 32'hC000_8000;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(0, va[k], vb[k]);
            await_grant(0, ok, seen);
            wait_resp(ok, cc, sc, wc);
            checks++;
            if (!ok || rsp_data !== ve[k] || rsp_id !== 2'd0) begin
                errors++; $display("FAIL corner_%0d: ok=%b id=%0d data=%h required 1 0 %h", k, ok, rsp_id, rsp_data, ve[k]);
            end
            step();
        end
    endtask

    task automatic test_async_reset;
        logic ok;
        logic [3:0] seen;
        int cc, sc, wc;
        rsp_ready = 1'b1;
        set_req(1, 16'd9, 16'd9);
        await_grant(1, ok, seen);
        repeat (4) step();
        checks++;
        if (mul_clr !== 1'b0 || mul_start !== 1'b0 || rsp_valid !== 1'b0 || mul_m !== 16'd9 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL arst_in_wait: clr=%b start=%b valid=%b m=%h id=%0d required 0 0 0 0009 1", mul_clr, mul_start, rsp_valid, mul_m, rsp_id);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mul_m !== 16'h0 || mul_q !== 16'h0 || rsp_id !== 2'd0 || mul_clr !== 1'b0 || mul_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            errors++; $display("FAIL arst_outputs: m=%h q=%h id=%0d clr=%b start=%b valid=%b data=%h required all 0", mul_m, mul_q, rsp_id, mul_clr, mul_start, rsp_valid, rsp_data);
        end
        step();
        rst_n = 1'b1;
        step();
        set_req(1, 16'd7, 16'd6);
        await_grant(1, ok, seen);
        checks++;
        if (!ok || seen !== 4'b0010) begin
            errors++; $display("FAIL arst_regrant: ok=%b ready=%b required 1 0010", ok, seen);
        end
        wait_resp(ok, cc, sc, wc);
        checks++;
        if (!ok || rsp_data !== 32'd42 || rsp_err !== 1'b0 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL arst_product: ok=%b id=%0d data=%h err=%b required 1 1 0000002a 0", ok, rsp_id, rsp_data, rsp_err);
        end
        step();
    endtask

`ifdef MUL_TIMEOUT_EN
    task automatic test_timeout;
        logic ok;
        logic [3:0] seen;
        int cc, sc, wc;
        rsp_ready = 1'b1;
        core_hang = 1'b1;
        set_req(2, 16'd1, 16'd1);
        await_grant(2, ok, seen);
        wait_resp(ok, cc, sc, wc);
        checks++;
        if (!ok || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            errors++; $display("FAIL timeout_rsp: ok=%b err=%b data=%h required 1 1 00000000", ok, rsp_err, rsp_data);
        end
        checks++;
        if (wc !== 64) begin
            errors++; $display("FAIL timeout_len: got %0d wait cycles required 64", wc);
        end
        step();
        core_hang = 1'b0;
        set_req(2, 16'd2, 16'd2);
        await_grant(2, ok, seen);
        wait_resp(ok, cc, sc, wc);
        checks++;
        if (!ok || rsp_err !== 1'b0 || rsp_data !== 32'd4) begin
            errors++; $display("FAIL timeout_recover: ok=%b err=%b data=%h required 1 0 00000004", ok, rsp_err, rsp_data);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_corners();
        test_async_reset();
`ifdef MUL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
